instr_dispatch_controller: RTL

Instruction-side initiator for the execution controllers; it drives the start/busy/done/next_pc protocol that those controllers answer. It fetches a 64-bit instruction from synchronous instruction memory at pc and decodes it into operation_type, register addresses and immediate. It pulses start to the selected execution unit, waits for completion, then adopts that unit's next_pc. It sits between instruction memory and the execution controllers (add controller = unit 0).

---
 rtl/instr_dispatch_controller_pkg.sv | 64 ++++++
 rtl/instr_dispatch_controller_decoder.sv | 35 +++
 rtl/instr_dispatch_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/instr_dispatch_controller_pkg.sv
// Shared constants, instruction layout and types for the instruction dispatch controller.
// Imported by the field decoder and by the top-level controller.
package instr_dispatch_controller_pkg;

    localparam int WORD_SIZE            = 32;
    localparam int PC_WIDTH             = 8;
    localparam int ADDR_WIDTH           = 5;
    localparam int OPERATION_TYPE_WIDTH = 2;
    localparam int NUM_UNITS            = 4;
    localparam int UNIT_SEL_WIDTH       = 2;
    localparam int ACCEPT_TIMEOUT       = 8;
    localparam int TIMEOUT_CNT_WIDTH    = 4;
    localparam int INSTR_WIDTH          = 64;
    localparam int RETIRED_WIDTH        = 16;

    localparam int OPC_LSB    = 60;
    localparam int OPTYPE_LSB = 58;
    localparam int RD_LSB     = 53;
    localparam int RS1_LSB    = 48;
    localparam int RS2_LSB    = 43;
    localparam int IMM_LSB    = 0;

    localparam logic [3:0] OPC_HALT      = 4'hF;
    localparam logic [3:0] OPC_NUM_UNITS = 4'(NUM_UNITS);

    localparam logic [OPERATION_TYPE_WIDTH-1:0] OP_TYPE_R = 2'd0;
    localparam logic [OPERATION_TYPE_WIDTH-1:0] OP_TYPE_I = 2'd1;

    localparam logic [TIMEOUT_CNT_WIDTH-1:0] TIMEOUT_LAST = 4'(ACCEPT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ERR_NONE           = 2'd0,
        ERR_ACCEPT_TIMEOUT = 2'd1,
        ERR_ILLEGAL_OPCODE = 2'd2
    } err_code_t;

    typedef enum logic [1:0] {
        CLS_UNIT    = 2'd0,
        CLS_HALT    = 2'd1,
        CLS_ILLEGAL = 2'd2
    } instr_class_t;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FETCH       = 4'd1,
        ST_FETCH_WAIT  = 4'd2,
        ST_DECODE      = 4'd3,
        ST_DISPATCH    = 4'd4,
        ST_WAIT_ACCEPT = 4'd5,
        ST_WAIT_DONE   = 4'd6,
        ST_UPDATE_PC   = 4'd7,
        ST_HALTED      = 4'd8,
        ST_ERROR       = 4'd9
    } state_t;

    typedef struct packed {
        logic [OPERATION_TYPE_WIDTH-1:0] op_type;
        logic [ADDR_WIDTH-1:0]           rd;
        logic [ADDR_WIDTH-1:0]           rs1;
        logic [ADDR_WIDTH-1:0]           rs2;
        logic [WORD_SIZE-1:0]            imm;
    } decoded_t;

endpackage

// File: rtl/instr_dispatch_controller_decoder.sv
// Combinational field extraction and opcode classification (unit / halt / illegal)
// for one 64-bit instruction word.
module instr_field_decoder
    import instr_dispatch_controller_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0]    instr_i,
    output decoded_t                  fields_o,
    output instr_class_t              class_o,
    output logic [UNIT_SEL_WIDTH-1:0] unit_sel_o
);

    logic [3:0] opcode;
    logic       unused_reserved;

    assign opcode          = instr_i[OPC_LSB +: 4];
    assign unused_reserved = ^instr_i[42:32];

    assign fields_o.op_type = instr_i[OPTYPE_LSB +: OPERATION_TYPE_WIDTH];
    assign fields_o.rd      = instr_i[RD_LSB +: ADDR_WIDTH];
    assign fields_o.rs1     = instr_i[RS1_LSB +: ADDR_WIDTH];
    assign fields_o.rs2     = instr_i[RS2_LSB +: ADDR_WIDTH];
    assign fields_o.imm     = instr_i[IMM_LSB +: WORD_SIZE];

    assign unit_sel_o = opcode[UNIT_SEL_WIDTH-1:0];

    always_comb begin
        class_o = CLS_ILLEGAL;
        if (opcode < OPC_NUM_UNITS) begin
            class_o = CLS_UNIT;
        end else if (opcode == OPC_HALT) begin
            class_o = CLS_HALT;
        end
    end

endmodule

// File: rtl/instr_dispatch_controller.sv
// Fetches, decodes and dispatches one instruction at a time to an execution unit,
// then follows the unit's next_pc. Handshake: start pulses only while the unit is not busy.
module instr_dispatch_controller
    import instr_dispatch_controller_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                run,
    input  logic [PC_WIDTH-1:0]                 start_pc,
    output logic [PC_WIDTH-1:0]                 imem_addr,
    output logic                                imem_rd_en,
    input  logic [INSTR_WIDTH-1:0]              imem_data,
    output logic [NUM_UNITS-1:0]                unit_start,
    input  logic [NUM_UNITS-1:0]                unit_busy,
    input  logic [NUM_UNITS-1:0]                unit_done,
    input  logic [NUM_UNITS*PC_WIDTH-1:0]       unit_next_pc,
    output logic [PC_WIDTH-1:0]                 pc,
    output logic [OPERATION_TYPE_WIDTH-1:0]     operation_type,
    output logic [ADDR_WIDTH-1:0]               source_1_address,
    output logic [ADDR_WIDTH-1:0]               source_2_address,
    output logic [ADDR_WIDTH-1:0]               destination_address,
    output logic [WORD_SIZE-1:0]                source_immediate_value,
    output logic                                halted,
    output logic                                error,
    output logic [1:0]                          error_code,
    output logic [RETIRED_WIDTH-1:0]            retired_count,
    output state_t                              dbg_state
);

    state_t                       state_q, state_d;
    logic [PC_WIDTH-1:0]          pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]       ir_q, ir_d;
    decoded_t                     fields_q, fields_d;
    logic [UNIT_SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]          npc_q, npc_d;
    err_code_t                    err_q, err_d;
    logic [RETIRED_WIDTH-1:0]     retired_q, retired_d;

    decoded_t                     dec_fields;
    instr_class_t                 dec_class;
    logic [UNIT_SEL_WIDTH-1:0]    dec_sel;

    instr_field_decoder u_decoder (
        .instr_i    (ir_q),
        .fields_o   (dec_fields),
        .class_o    (dec_class),
        .unit_sel_o (dec_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            fields_q  <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            npc_q     <= '0;
            err_q     <= ERR_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            fields_q  <= fields_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            npc_q     <= npc_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        fields_d   = fields_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        npc_d      = npc_q;
        err_d      = err_q;
        retired_d  = retired_q;
        unit_start = '0;
        imem_rd_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    pc_d    = start_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_rd_en = 1'b1;
                state_d    = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                ir_d    = imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                fields_d = dec_fields;
                sel_d    = dec_sel;
                case (dec_class)
                    CLS_UNIT: state_d = ST_DISPATCH;
                    CLS_HALT: begin
                        retired_d = retired_q + 16'd1;
                        state_d   = ST_HALTED;
                    end
                    default: begin
                        err_d   = ERR_ILLEGAL_OPCODE;
                        state_d = ST_ERROR;
                    end
                endcase
            end
            ST_DISPATCH: begin
                // A still-busy unit cannot take a new start; hold off without pulsing.
                if (!unit_busy[sel_q]) begin
                    unit_start[sel_q] = 1'b1;
                    cnt_d             = '0;
                    state_d           = ST_WAIT_ACCEPT;
                end
            end
            ST_WAIT_ACCEPT: begin
                if (unit_busy[sel_q]) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = ERR_ACCEPT_TIMEOUT;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (unit_done[sel_q] && !unit_busy[sel_q]) begin
                    npc_d   = unit_next_pc[int'(sel_q)*PC_WIDTH +: PC_WIDTH];
                    state_d = ST_UPDATE_PC;
                end
            end
            ST_UPDATE_PC: begin
                pc_d      = npc_q;
                retired_d = retired_q + 16'd1;
                state_d   = ST_FETCH;
            end
            ST_HALTED: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign imem_addr              = pc_q;
    assign pc                     = pc_q;
    assign operation_type         = fields_q.op_type;
    assign source_1_address       = fields_q.rs1;
    assign source_2_address       = fields_q.rs2;
    assign destination_address    = fields_q.rd;
    assign source_immediate_value = fields_q.imm;
    assign halted                 = (state_q == ST_HALTED);
    assign error                  = (state_q == ST_ERROR);
    assign error_code             = err_q;
    assign retired_count          = retired_q;
    assign dbg_state              = state_q;

endmodule
